// File: rtl/hyper_bist_pkg.sv
// Shared types and constants for the hyper_xface memory BIST.
package hyper_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrWaitBusy,
        StWrWaitIdle,
        StRdReq,
        StRdWaitBusy,
        StRdData,
        StDone
    } bist_state_t;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_WALK1 = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_ADDR  = 2'd3
    } bist_mode_t;

    // Galois form of x^32+x^22+x^2+x+1, shifting right.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/hyper_bist_pattern.sv
// Data pattern generator; the LFSR is reseeded so write and read phases replay the same sequence.
module hyper_bist_pattern
    import hyper_bist_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  idx,
    input  logic [ADDR_W-1:0] addr,
    input  logic              advance,
    input  logic              reseed,
    output logic [31:0]       pattern
);

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed) begin
            lfsr_d = LFSR_SEED;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        pattern = 32'h0;
        unique case (bist_mode_t'(mode))
            MODE_INC:   pattern = 32'(idx);
            MODE_WALK1: pattern = 32'd1 << idx[4:0];
            MODE_LFSR:  pattern = lfsr_q;
            MODE_ADDR:  pattern = 32'(addr);
            default:    pattern = 32'h0;
        endcase
    end

endmodule

// File: rtl/hyper_mem_bist.sv
// Write/readback traffic generator and checker for the hyper_xface user port.
module hyper_mem_bist
    import hyper_bist_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RD_BURST  = 4,
    parameter int unsigned ADDR_STEP = 2,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              wr_req,
    output logic              rd_req,
    output logic [3:0]        wr_byte_en,
    output logic              mem_or_reg,
    output logic [5:0]        rd_num_dwords,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_d,
    input  logic [DATA_W-1:0] rd_d,
    input  logic              rd_rdy,
    input  logic              busy,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic              timeout
);

    localparam int unsigned       TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(RD_BURST);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    bist_state_t       state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] base_q, base_d, cur_addr_q, cur_addr_d, ferr_addr_q, ferr_addr_d;
    logic [CNT_W-1:0]  num_q, num_d, idx_q, idx_d, err_cnt_q, err_cnt_d;
    logic [5:0]        len_q, len_d, beat_q, beat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] ferr_data_q, ferr_data_d;
    logic              wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic              running_q, running_d, done_q, done_d, timeout_q, timeout_d;

    logic              advance, reseed, beat_ok, tmo_hit;
    logic [31:0]       pattern;
    logic [CNT_W-1:0]  idx_inc, rem;
    logic [5:0]        beats_now;

    hyper_bist_pattern #(
        .CNT_W    (CNT_W),
        .ADDR_W   (ADDR_W),
        .LFSR_SEED(LFSR_SEED)
    ) u_pattern (
        .clk    (clk),
        .reset_l(reset_l),
        .mode   (mode_q),
        .idx    (idx_q),
        .addr   (cur_addr_q),
        .advance(advance),
        .reseed (reseed),
        .pattern(pattern)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        num_d       = num_q;
        idx_d       = idx_q;
        cur_addr_d  = cur_addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        err_cnt_d   = err_cnt_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;
        running_d   = running_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        tmo_d       = tmo_q;
        wr_req_d    = 1'b0;
        rd_req_d    = 1'b0;
        advance     = 1'b0;
        reseed      = 1'b0;
        idx_inc     = idx_q + 1'b1;
        rem         = num_q - idx_q;
        beat_ok     = rd_rdy && (beat_q < len_q);
        beats_now   = beat_q + {5'd0, beat_ok};
        tmo_hit     = (tmo_q == TMO_LAST);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    mode_d      = mode;
                    base_d      = base_addr;
                    num_d       = num_words;
                    idx_d       = '0;
                    cur_addr_d  = base_addr;
                    reseed      = 1'b1;
                    err_cnt_d   = '0;
                    ferr_addr_d = '0;
                    ferr_data_d = '0;
                    timeout_d   = 1'b0;
                    done_d      = (num_words == '0);
                    running_d   = (num_words != '0);
                    state_d     = (num_words == '0) ? StDone : StWrReq;
                end
            end
            StWrReq: begin
                if (!busy) begin
                    wr_req_d = 1'b1;
                    state_d  = StWrWaitBusy;
                end
            end
            StWrWaitBusy: begin
                if (busy) begin
                    state_d = StWrWaitIdle;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StWrWaitIdle: begin
                if (!busy) begin
                    idx_d      = idx_inc;
                    cur_addr_d = cur_addr_q + STEP;
                    advance    = 1'b1;
                    state_d    = StWrReq;
                    if (idx_inc == num_q) begin
                        idx_d      = '0;
                        cur_addr_d = base_q;
                        reseed     = 1'b1;
                        state_d    = StRdReq;
                    end
                end
            end
            StRdReq: begin
                len_d = (rem < BURST_CNT) ? rem[5:0] : BURST_CNT[5:0];
                if (!busy) begin
                    rd_req_d = 1'b1;
                    beat_d   = '0;
                    state_d  = StRdWaitBusy;
                end
            end
            StRdWaitBusy: begin
                if (busy) begin
                    state_d = StRdData;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StRdData: begin
                if (beat_ok) begin
                    idx_d      = idx_inc;
                    cur_addr_d = cur_addr_q + STEP;
                    advance    = 1'b1;
                    if (rd_d != DATA_W'(pattern)) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (err_cnt_q == '0) begin
                            ferr_addr_d = cur_addr_q;
                            ferr_data_d = rd_d;
                        end
                    end
                end
                beat_d = beats_now;
                // A beat landing with busy's fall is counted before the completion test.
                if (beats_now == len_q && !busy) begin
                    state_d = (idx_d == num_q) ? StDone : StRdReq;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StDone && state_q != StDone) begin
            running_d = 1'b0;
            done_d    = 1'b1;
        end

        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (state_q inside {StWrWaitBusy, StRdWaitBusy, StRdData}) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            base_q      <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            cur_addr_q  <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            err_cnt_q   <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            tmo_q       <= '0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            cur_addr_q  <= cur_addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            err_cnt_q   <= err_cnt_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            tmo_q       <= tmo_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
        end
    end

    assign wr_req         = wr_req_q;
    assign rd_req         = rd_req_q;
    assign wr_byte_en     = 4'hF;
    assign mem_or_reg     = 1'b0;
    assign rd_num_dwords  = len_q;
    assign addr           = cur_addr_q;
    assign wr_d           = DATA_W'(pattern);
    assign running        = running_q;
    assign done           = done_q;
    assign pass           = done_q && (err_cnt_q == '0) && !timeout_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;
    assign timeout        = timeout_q;

    p_data_w: assert property (@(posedge clk) DATA_W == 32)
        else $error("hyper_mem_bist: DATA_W must be 32");

endmodule

// File: tb/tb_hyper_mem_bist.sv
// Directed bench for hyper_mem_bist with a small behavioural hyper_xface slave.
module tb_hyper_mem_bist;

    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] base_addr = 32'h0;
    logic [15:0] num_words = 16'h0;
    logic        wr_req, rd_req, mem_or_reg, running, done, pass, timeout;
    logic [3:0]  wr_byte_en;
    logic [5:0]  rd_num_dwords;
    logic [31:0] addr, wr_d, first_err_addr, first_err_data;
    logic [15:0] err_cnt;
    logic [31:0] rd_d = 32'h0;
    logic        rd_rdy = 1'b0;
    logic        busy = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hyper_mem_bist #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .start         (start),
        .mode          (mode),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .wr_req        (wr_req),
        .rd_req        (rd_req),
        .wr_byte_en    (wr_byte_en),
        .mem_or_reg    (mem_or_reg),
        .rd_num_dwords (rd_num_dwords),
        .addr          (addr),
        .wr_d          (wr_d),
        .rd_d          (rd_d),
        .rd_rdy        (rd_rdy),
        .busy          (busy),
        .running       (running),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .timeout       (timeout)
    );

    // Behavioural slave: latency, busy window, burst beats, optional faults.
    logic        stuck_low = 1'b0;
    logic        fast_end = 1'b0;
    logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
    logic [31:0] mem [0:511];
    int          sl_st = 0;
    int          sl_cnt = 0;
    logic [31:0] sl_addr = 32'h0;
    logic [31:0] sl_data = 32'h0;
    logic [5:0]  sl_len = 6'd0;
    logic        sl_wr = 1'b0;

    always @(posedge clk) begin
        if (!reset_l) begin
            busy   <= 1'b0;
            rd_rdy <= 1'b0;
            rd_d   <= 32'h0;
            sl_st  <= 0;
        end else begin
            case (sl_st)
                0: begin
                    rd_rdy <= 1'b0;
                    if (!stuck_low && wr_req) begin
                        sl_addr <= addr;
                        sl_data <= wr_d;
                        sl_wr   <= 1'b1;
                        sl_cnt  <= 1;
                        sl_st   <= 1;
                    end else if (!stuck_low && rd_req) begin
                        sl_addr <= addr;
                        sl_len  <= rd_num_dwords;
                        sl_wr   <= 1'b0;
                        sl_cnt  <= 1;
                        sl_st   <= 1;
                    end
                end
                1: begin
                    if (sl_cnt == 0) begin
                        busy   <= 1'b1;
                        sl_cnt <= 2;
                        sl_st  <= sl_wr ? 2 : 3;
                    end else begin
                        sl_cnt <= sl_cnt - 1;
                    end
                end
                2: begin
                    if (sl_cnt == 0) begin
                        mem[sl_addr[9:1]] <= sl_data;
                        busy              <= 1'b0;
                        sl_st             <= 0;
                    end else begin
                        sl_cnt <= sl_cnt - 1;
                    end
                end
                3: begin
                    rd_rdy  <= 1'b1;
                    rd_d    <= mem[sl_addr[9:1]] ^ {31'd0, sl_addr == corrupt_addr};
                    sl_addr <= sl_addr + 32'd2;
                    sl_len  <= sl_len - 6'd1;
                    if (sl_len == 6'd1) begin
                        sl_st <= 4;
                        if (fast_end) busy <= 1'b0;
                    end
                end
                4: begin
                    rd_rdy <= 1'b0;
                    busy   <= 1'b0;
                    sl_st  <= 0;
                end
                default: sl_st <= 0;
            endcase
        end
    end

    // Request monitor.
    int          n_wr = 0;
    int          n_rd = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] wd_log[$];
    logic [5:0]  len_log[$];

    always @(posedge clk) begin
        if (wr_req) begin
            n_wr <= n_wr + 1;
            last_wr_addr <= addr;
            wd_log.push_back(wr_d);
        end
        if (rd_req) begin
            n_rd <= n_rd + 1;
            len_log.push_back(rd_num_dwords);
        end
    end

    task automatic pulse_start(input logic [1:0] m, input logic [31:0] b, input logic [15:0] n);
        @(negedge clk);
        mode = m;
        base_addr = b;
        num_words = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_l = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wr_req, rd_req, mem_or_reg, running, done, pass, timeout} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {wr_req, rd_req, mem_or_reg, running, done, pass, timeout});
        end
        checks++;
        if (wr_byte_en !== 4'hF) begin
            failures++;
            $display("FAIL reset_byte_en got=%h exp=f", wr_byte_en);
        end
        checks++;
        if ({addr, wr_d, first_err_addr, first_err_data, err_cnt, rd_num_dwords} !== '0) begin
            failures++;
            $display("FAIL reset_data addr=%h wr_d=%h fea=%h fed=%h err=%0d len=%0d exp=all zero",
                     addr, wr_d, first_err_addr, first_err_data, err_cnt, rd_num_dwords);
        end
        reset_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_increment;
        int w0, r0, l0;
        bit ok;
        logic [17:0] lens;
        w0 = n_wr;
        r0 = n_rd;
        l0 = len_log.size();
        pulse_start(2'd0, 32'h0, 16'd10);
        wait_done(3000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL inc_done got=0 exp=1");
        end
        checks++;
        if (n_wr - w0 != 10) begin
            failures++;
            $display("FAIL inc_wr_count got=%0d exp=10", n_wr - w0);
        end
        checks++;
        if (n_rd - r0 != 3) begin
            failures++;
            $display("FAIL inc_rd_count got=%0d exp=3", n_rd - r0);
        end
        lens = (len_log.size() >= l0 + 3) ?
               {len_log[l0], len_log[l0+1], len_log[l0+2]} : 18'h3FFFF;
        checks++;
        if (lens !== {6'd4, 6'd4, 6'd2}) begin
            failures++;
            $display("FAIL inc_burst_lens got=%h exp=%h", lens, {6'd4, 6'd4, 6'd2});
        end
        checks++;
        if ({pass, err_cnt} !== {1'b1, 16'd0}) begin
            failures++;
            $display("FAIL inc_pass got pass=%b err=%0d exp pass=1 err=0", pass, err_cnt);
        end
        checks++;
        if (mem[9] !== 32'd9) begin
            failures++;
            $display("FAIL inc_mem9 got=%h exp=00000009", mem[9]);
        end
    endtask

    task automatic test_lfsr;
        int w0, k0;
        bit ok;
        logic [95:0] words;
        w0 = n_wr;
        k0 = wd_log.size();
        pulse_start(2'd2, 32'h100, 16'd64);
        wait_done(6000, ok);
        checks++;
        if (!ok || n_wr - w0 != 64) begin
            failures++;
            $display("FAIL lfsr_done got done=%b writes=%0d exp done=1 writes=64", ok, n_wr - w0);
        end
        words = (wd_log.size() >= k0 + 5) ?
                {wd_log[k0], wd_log[k0+1], wd_log[k0+4]} : '1;
        checks++;
        if (words !== {32'hACE1_2468, 32'h5670_9234, 32'h8AEE_1245}) begin
            failures++;
            $display("FAIL lfsr_words got=%h exp=ace124685670923 48aee1245", words);
        end
        checks++;
        if (last_wr_addr !== 32'h17E) begin
            failures++;
            $display("FAIL lfsr_last_addr got=%h exp=0000017e", last_wr_addr);
        end
        checks++;
        if (pass !== 1'b1 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL lfsr_pass got pass=%b err=%0d exp pass=1 err=0", pass, err_cnt);
        end
    endtask

    task automatic test_walk1_fast_end;
        bit ok;
        fast_end = 1'b1;
        pulse_start(2'd1, 32'h0, 16'd40);
        wait_done(5000, ok);
        fast_end = 1'b0;
        checks++;
        if (!ok || pass !== 1'b1) begin
            failures++;
            $display("FAIL walk1_pass got done=%b pass=%b err=%0d exp done=1 pass=1",
                     ok, pass, err_cnt);
        end
        checks++;
        if ({mem[31], mem[33]} !== {32'h8000_0000, 32'h0000_0002}) begin
            failures++;
            $display("FAIL walk1_mem got=%h %h exp=80000000 00000002", mem[31], mem[33]);
        end
    endtask

    task automatic test_corrupt;
        bit ok;
        corrupt_addr = 32'h4A;
        pulse_start(2'd3, 32'h40, 16'd10);
        wait_done(3000, ok);
        corrupt_addr = 32'hFFFF_FFFF;
        checks++;
        if (!ok || err_cnt !== 16'd1) begin
            failures++;
            $display("FAIL corrupt_err_cnt got done=%b err=%0d exp done=1 err=1", ok, err_cnt);
        end
        checks++;
        if ({first_err_addr, first_err_data} !== {32'h4A, 32'h4B}) begin
            failures++;
            $display("FAIL corrupt_first got addr=%h data=%h exp addr=0000004a data=0000004b",
                     first_err_addr, first_err_data);
        end
        checks++;
        if (pass !== 1'b0) begin
            failures++;
            $display("FAIL corrupt_pass got=%b exp=0", pass);
        end
    endtask

    task automatic test_timeout;
        int w0;
        bit ok;
        stuck_low = 1'b1;
        w0 = n_wr;
        pulse_start(2'd0, 32'h0, 16'd5);
        repeat (20) @(negedge clk);
        checks++;
        if ({timeout, running} !== 2'b01) begin
            failures++;
            $display("FAIL tmo_early got timeout=%b running=%b exp timeout=0 running=1",
                     timeout, running);
        end
        wait_done(TIMEOUT + 20, ok);
        checks++;
        if (!ok || {timeout, pass, running} !== 3'b100) begin
            failures++;
            $display("FAIL tmo_flags got done=%b timeout=%b pass=%b running=%b exp 1 1 0 0",
                     ok, timeout, pass, running);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n_wr - w0 != 1) begin
            failures++;
            $display("FAIL tmo_wr_count got=%0d exp=1", n_wr - w0);
        end
        stuck_low = 1'b0;
    endtask

    task automatic test_zero_restart;
        int w0, r0;
        bit ok;
        w0 = n_wr;
        r0 = n_rd;
        pulse_start(2'd0, 32'h0, 16'd0);
        checks++;
        if ({done, pass, running} !== 3'b110) begin
            failures++;
            $display("FAIL zero_done got done=%b pass=%b running=%b exp 1 1 0",
                     done, pass, running);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_wr != w0 || n_rd != r0) begin
            failures++;
            $display("FAIL zero_no_req got wr=%0d rd=%0d exp 0 0", n_wr - w0, n_rd - r0);
        end
        pulse_start(2'd0, 32'h0, 16'd8);
        repeat (10) @(negedge clk);
        pulse_start(2'd1, 32'h200, 16'd3);
        wait_done(3000, ok);
        checks++;
        if (!ok || n_wr - w0 != 8 || pass !== 1'b1) begin
            failures++;
            $display("FAIL restart_ignored got done=%b writes=%0d pass=%b exp 1 8 1",
                     ok, n_wr - w0, pass);
        end
        checks++;
        if (mem[7] !== 32'd7) begin
            failures++;
            $display("FAIL restart_mem7 got=%h exp=00000007", mem[7]);
        end
    endtask

    task automatic test_mid_reset;
        int w1, r1;
        bit seen, ok;
        seen = 1'b0;
        pulse_start(2'd0, 32'h0, 16'd10);
        for (int i = 0; i < 2000; i++) begin
            if (rd_rdy) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midrst_beat got no read beat exp a beat");
        end
        reset_l = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_req, rd_req, running, done, pass, timeout, wr_byte_en, addr, wr_d, err_cnt,
             rd_num_dwords} !== {6'b0, 4'hF, 32'h0, 32'h0, 16'h0, 6'h0}) begin
            failures++;
            $display("FAIL midrst_outputs got ctl=%b be=%h addr=%h wr_d=%h err=%0d len=%0d exp 0/f/0",
                     {wr_req, rd_req, running, done, pass, timeout}, wr_byte_en, addr, wr_d,
                     err_cnt, rd_num_dwords);
        end
        w1 = n_wr;
        r1 = n_rd;
        repeat (4) @(negedge clk);
        reset_l = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (n_wr != w1 || n_rd != r1 || running !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet got wr=%0d rd=%0d running=%b exp 0 0 0",
                     n_wr - w1, n_rd - r1, running);
        end
        pulse_start(2'd0, 32'h0, 16'd10);
        wait_done(3000, ok);
        checks++;
        if (!ok || pass !== 1'b1 || n_wr - w1 != 10) begin
            failures++;
            $display("FAIL midrst_rerun got done=%b pass=%b writes=%0d exp 1 1 10",
                     ok, pass, n_wr - w1);
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_lfsr();
        test_walk1_fast_end();
        test_corrupt();
        test_timeout();
        test_zero_restart();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=expired exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hyper_mem_bist.md
Name: hyper_mem_bist

Overview:
Synthesizable, parametrised traffic generator and checker for the hyper_xface user port. It is the successor to the fixed single-dword write/read bench stimulus.
- Write phase: writes a configurable region of HyperRAM with one of four data patterns, one dword per request.
- Read phase: reads the region back in parametrised bursts and compares every returned dword.
- Reporting: error count, first failing address and data, timeout status.
- Placement: sits between the system/test harness and hyper_xface, and is usable in silicon bring-up and in simulation.

Parameters:
ADDR_W, 32, width of addr to hyper_xface
DATA_W, 32, dword width (fixed 32 by hyper_xface; checked by assertion)
CNT_W, 16, width of dword counter / num_words / err_cnt
RD_BURST, 4, max dwords per read request (1..63)
ADDR_STEP, 2, addr increment per dword (HyperRAM 16-bit word addressing)
TIMEOUT, 1024, cycles allowed for busy to rise after a request, or for a burst to complete
LFSR_SEED, 32'hACE1_2468, LFSR reset/reseed value (nonzero)

Ports:
clk  in  1  system clock
reset_l  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, sampled only in IDLE/DONE
mode  in  2  0 incrementing, 1 walking-one, 2 LFSR32, 3 address-as-data
base_addr  in  ADDR_W  first address
num_words  in  CNT_W  dwords to test; 0 means finish immediately with pass
wr_req  out  1  one-cycle write request
rd_req  out  1  one-cycle read request
wr_byte_en  out  4  always 4'hF
mem_or_reg  out  1  always 0 (memory space)
rd_num_dwords  out  6  burst length of current read
addr  out  ADDR_W  request address
wr_d  out  DATA_W  write data
rd_d  in  DATA_W  read data
rd_rdy  in  1  rd_d valid strobe
busy  in  1  controller busy
running  out  1  test in progress
done  out  1  level; high from test end until next start
pass  out  1  valid when done: err_cnt==0 && !timeout
err_cnt  out  CNT_W  mismatches, saturating at all-ones
first_err_addr  out  ADDR_W  address of first mismatch
first_err_data  out  DATA_W  rd_d of first mismatch
timeout  out  1  sticky, set on handshake timeout

Behaviour:
- Reset (reset_l==0 at clk edge): every output is 0 except wr_byte_en=4'hF. FSM goes to IDLE and the LFSR loads LFSR_SEED. Reset mid-test abandons the test immediately; no further requests are issued.
- Capture: on start, latch mode, base_addr and num_words. Clear err_cnt, first_err_*, timeout and done. Set running. Reseed the pattern generator. Go to WR_REQ, or straight to DONE if num_words==0.
- FSM states: IDLE, WR_REQ, WR_WAIT_BUSY, WR_WAIT_IDLE, RD_REQ, RD_WAIT_BUSY, RD_DATA, DONE.
- WR_REQ: wait for busy==0. Then pulse wr_req for exactly 1 cycle, with addr = base_addr + idx*ADDR_STEP and wr_d = pattern(idx). Go to WR_WAIT_BUSY.
- WR_WAIT_BUSY: wait for busy==1, then go to WR_WAIT_IDLE.
- WR_WAIT_IDLE: on busy==0, increment idx. If idx==num_words, reseed the pattern, set idx=0 and go to RD_REQ; otherwise go to WR_REQ.
- addr and wr_d are held stable from the request cycle until busy falls.
- RD_REQ: burst length len = min(RD_BURST, num_words-idx). Wait for busy==0, then pulse rd_req for 1 cycle with rd_num_dwords=len. Go to RD_WAIT_BUSY, then to RD_DATA on busy==1.
- RD_DATA, per rd_rdy beat:
  - Compare rd_d with pattern(idx); on mismatch, increment err_cnt.
  - On the first mismatch only, capture first_err_addr and first_err_data.
  - Increment idx and advance the pattern.
- End of burst: after len beats and busy==0, go to RD_REQ, or to DONE when idx==num_words.
- Stray beats: rd_rdy beats beyond len are ignored.
- If rd_rdy and busy falling occur in the same cycle, the beat is counted before the completion check.
- Timeout: a counter clears on every state entry. It measures cycles waiting for busy==1 in *_WAIT_BUSY, and total burst time in RD_DATA. Reaching TIMEOUT sets timeout and forces DONE.
- DONE: running=0, done=1. start restarts the test. start during running is ignored.
- Patterns, for idx = dword index:
  - Mode 0: idx zero-extended.
  - Mode 1: 1<<(idx mod 32).
  - Mode 2: Galois LFSR x^32+x^22+x^2+x+1, advanced once per dword; word 0 = seed.
  - Mode 3: addr value truncated/extended to 32 bits.
- Width rules: idx and addr arithmetic are modulo 2^CNT_W and 2^ADDR_W. Address wrap is allowed and not flagged.

Decomposition:
- Package hyper_bist_pkg holds:
  - state enum bist_state_t;
  - mode enum bist_mode_t (MODE_INC, MODE_WALK1, MODE_LFSR, MODE_ADDR);
  - LFSR polynomial constant LFSR_TAPS = 32'h8020_0003.
- Sub-module hyper_bist_pattern: inputs mode, idx, addr, advance, reseed; output pattern. It owns the LFSR register, and the write and read phases share it via reseed.

Test Plan:
1. Error-free increment: mode 0, base 0, num_words=10, RD_BURST=4, hyper_xface + s27ks0641 -> 10 wr_req pulses, then 3 rd_req with rd_num_dwords 4,4,2; done=1, pass=1, err_cnt=0.
2. LFSR readback: mode 2, num_words=64, base 32'h100 -> first wr_d=32'hACE1_2468, last addr=32'h17E; pass=1.
3. Single corrupted beat: behavioural slave flips bit 0 of read dword 5, mode 3, base 32'h40 -> err_cnt=1, first_err_addr=32'h4A, first_err_data=32'h4B.
4. Busy stuck low: slave never raises busy -> timeout=1 after TIMEOUT cycles, done=1, pass=0, no second wr_req.
5. Zero-length and restart: num_words=0 -> done next cycle, pass=1, no requests. start pulsed while running -> ignored, request count unchanged.
6. Mid-test reset: assert reset_l=0 during RD_DATA of test 1 -> all outputs at reset values next cycle. New start completes with pass=1.
